alarm_snooze_ctrl: RTL
======================

ALARM_SNOOZE_CTRL -- requirements
Module: alarm_snooze_ctrl

Interface
REQ-001 SHALL have parameters: SNOOZE_SEC, default 540, snooze length in seconds; RING_TIMEOUT, default 120, auto-stop ring length in seconds; MAX_SNOOZE, default 3, snoozes allowed per alarm event.
REQ-002 SHALL have port: clk  in  1  one clock, 1 Hz time pulse, rising-edge active.
REQ-003 SHALL have port: rst  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: alarm_match  in  1  high while time hrs/min equals alarm hrs/min.
REQ-005 SHALL have port: alarm_on  in  1  alarm armed, level.
REQ-006 SHALL have port: snooze  in  1  snooze button, level.
REQ-007 SHALL have port: stop  in  1  stop button, level.
REQ-008 SHALL have port: day  in  3  day of week, 0..6; 5 and 6 are weekend.
REQ-009 SHALL have port: buzz  out  1  buzzer drive, 1 s on / 1 s off pattern.
REQ-010 SHALL have port: ringing  out  1  high in RING state.
REQ-011 SHALL have port: snoozing  out  1  high in SNOOZE state.
REQ-012 SHALL have port: snz_left  out  10  seconds remaining in the current snooze, 0 outside SNOOZE.
REQ-013 SHALL have port: snz_used  out  2  snoozes consumed in the current event.

Function
REQ-014 SHALL register alarm_match and snooze; trig = alarm_match & !match_q; snz_edge = snooze & !snooze_q.
REQ-015 SHALL implement states IDLE, RING, SNOOZE, DONE; state outputs (ringing, snoozing, buzz) are decoded from registers, with no input-to-output combinational path.
REQ-016 IDLE -> RING when trig & alarm_on & day not in {5,6}; on entry ring_ct=0, phase=1, snz_used=0.
REQ-017 RING priority: !alarm_on -> IDLE; else stop -> DONE; else snz_edge & snz_used<MAX_SNOOZE -> SNOOZE, snz_ct=SNOOZE_SEC-1, snz_used+1; else ring_ct==RING_TIMEOUT-1 -> DONE; else ring_ct+1, phase toggles.
REQ-018 In RING, snz_edge with snz_used==MAX_SNOOZE SHALL be ignored; ringing continues.
REQ-019 SNOOZE priority: !alarm_on -> IDLE; else stop -> DONE; else snz_ct==0 -> RING, ring_ct=0, phase=1; else snz_ct-1.
REQ-020 DONE -> IDLE when alarm_match==0; otherwise hold in DONE.
REQ-021 buzz SHALL equal ringing & phase, so the first RING cycle has buzz=1.
REQ-022 snz_left SHALL equal snz_ct in SNOOZE and 0 otherwise; snz_used SHALL hold its value through DONE and IDLE until the next RING entry.
REQ-023 Counters SHALL never wrap: ring_ct is 7 bits and saturates by exit at 119; snz_ct is 10 bits and exits at 0.
REQ-024 Weekend check SHALL apply only at IDLE->RING; a day change during RING or SNOOZE has no effect.
REQ-025 If trig coincides with stop or snooze in IDLE, the IDLE rule alone SHALL apply.

Reset
REQ-026 While rst=0: state=IDLE, match_q=0, snooze_q=0, ring_ct=0, snz_ct=0, snz_used=0, phase=0; buzz=0, ringing=0, snoozing=0, snz_left=0.
REQ-027 Reset assertion mid-RING or mid-SNOOZE SHALL abort immediately, asynchronously.
REQ-028 Release with alarm_match=1 SHALL produce trig on the first clock, since match_q=0.

Structure
REQ-029 SHALL place the state enum, SNOOZE_SEC, RING_TIMEOUT, MAX_SNOOZE defaults and weekend day codes 5,6 in shared package alarm_pkg.
REQ-030 SHALL instantiate sub-module rise_det twice, for alarm_match and snooze; rise_det has ports clk, rst, d, rise.

Verification
REQ-031 Test: day=2, alarm_on=1, alarm_match rises -> next cycle ringing=1, buzz=1; buzz follows 1,0,1,0 pattern.
REQ-032 Test: day=5, alarm_match rises -> stays IDLE, buzz=0 for 60 cycles.
REQ-033 Test: ring 10 s, pulse snooze -> snoozing=1, snz_left=539 and decrements; after 540 cycles ringing=1, snz_used=1.
REQ-034 Test: four snooze pulses across events -> 4th ignored, snz_used=3, ringing stays 1.
REQ-035 Test: no buttons in RING -> after 120 cycles DONE, buzz=0; DONE->IDLE when alarm_match falls; no retrigger.
REQ-036 Test: rst=0 mid-SNOOZE -> all outputs 0 immediately; stop and !alarm_on each exit RING and SNOOZE per the priority in REQ-017 and REQ-019.

Source files
------------

// File: rtl/alarm_snooze_ctrl_pkg.sv
// Shared types and defaults for the alarm/snooze controller.
// Holds the FSM state encoding, timing defaults and weekend day codes.
package alarm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RING   = 2'd1,
    ST_SNOOZE = 2'd2,
    ST_DONE   = 2'd3
  } alarm_state_t;

  localparam int unsigned SNOOZE_SEC_DEF   = 540;
  localparam int unsigned RING_TIMEOUT_DEF = 120;
  localparam int unsigned MAX_SNOOZE_DEF   = 3;

  localparam logic [2:0] DAY_SAT = 3'd5;
  localparam logic [2:0] DAY_SUN = 3'd6;

  function automatic logic is_weekend(input logic [2:0] day);
    return (day == DAY_SAT) || (day == DAY_SUN);
  endfunction

endpackage

// File: rtl/alarm_snooze_ctrl_if.sv
// Bundle of the alarm controller's user-facing signals.
// The master side drives buttons/time inputs, the slave side is the controller.
interface alarm_snooze_ctrl_if;
  logic       alarm_match;
  logic       alarm_on;
  logic       snooze;
  logic       stop;
  logic [2:0] day;
  logic       buzz;
  logic       ringing;
  logic       snoozing;
  logic [9:0] snz_left;
  logic [1:0] snz_used;

  modport master (
    output alarm_match, alarm_on, snooze, stop, day,
    input  buzz, ringing, snoozing, snz_left, snz_used
  );

  modport slave (
    input  alarm_match, alarm_on, snooze, stop, day,
    output buzz, ringing, snoozing, snz_left, snz_used
  );
endinterface

// File: rtl/alarm_snooze_ctrl_rise_det.sv
// Rising-edge detector: registers d and flags a 0->1 transition.
// The registered copy clears on reset so a high input right after release reads as a rise.
module rise_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic r_d_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_d_q <= 1'b0;
    else      r_d_q <= d;
  end

  assign rise = d & ~r_d_q;

endmodule

// File: rtl/alarm_snooze_ctrl.sv
// Alarm ring / snooze controller running off a 1 Hz clock.
// All user-visible outputs decode from registers only.
module alarm_snooze_ctrl
  import alarm_pkg::*;
#(
  parameter int unsigned SNOOZE_SEC   = SNOOZE_SEC_DEF,
  parameter int unsigned RING_TIMEOUT = RING_TIMEOUT_DEF,
  parameter int unsigned MAX_SNOOZE   = MAX_SNOOZE_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       alarm_match,
  input  logic       alarm_on,
  input  logic       snooze,
  input  logic       stop,
  input  logic [2:0] day,
  output logic       buzz,
  output logic       ringing,
  output logic       snoozing,
  output logic [9:0] snz_left,
  output logic [1:0] snz_used
);

  localparam logic [6:0] RING_LAST = 7'(RING_TIMEOUT - 1);
  localparam logic [9:0] SNZ_LOAD  = 10'(SNOOZE_SEC - 1);
  localparam logic [1:0] SNZ_MAX   = 2'(MAX_SNOOZE);

  logic w_trig;
  logic w_snz_edge;

  alarm_state_t r_state, w_state_next;
  logic [6:0]   r_ring_ct, w_ring_ct_next;
  logic [9:0]   r_snz_ct,  w_snz_ct_next;
  logic [1:0]   r_snz_used, w_snz_used_next;
  logic         r_phase, w_phase_next;

  rise_det u_match_rise (
    .clk  (clk),
    .rst  (rst),
    .d    (alarm_match),
    .rise (w_trig)
  );

  rise_det u_snooze_rise (
    .clk  (clk),
    .rst  (rst),
    .d    (snooze),
    .rise (w_snz_edge)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_ring_ct  <= '0;
      r_snz_ct   <= '0;
      r_snz_used <= '0;
      r_phase    <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_ring_ct  <= w_ring_ct_next;
      r_snz_ct   <= w_snz_ct_next;
      r_snz_used <= w_snz_used_next;
      r_phase    <= w_phase_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_ring_ct_next  = r_ring_ct;
    w_snz_ct_next   = r_snz_ct;
    w_snz_used_next = r_snz_used;
    w_phase_next    = r_phase;

    unique case (r_state)
      ST_IDLE: begin
        // Buttons are deliberately ignored here; only a weekday trigger starts a ring.
        if (w_trig && alarm_on && !is_weekend(day)) begin
          w_state_next    = ST_RING;
          w_ring_ct_next  = '0;
          w_phase_next    = 1'b1;
          w_snz_used_next = '0;
        end
      end

      ST_RING: begin
        if (!alarm_on) begin
          w_state_next = ST_IDLE;
        end else if (stop) begin
          w_state_next = ST_DONE;
        end else if (w_snz_edge && (r_snz_used < SNZ_MAX)) begin
          w_state_next    = ST_SNOOZE;
          w_snz_ct_next   = SNZ_LOAD;
          w_snz_used_next = r_snz_used + 2'd1;
        end else if (r_ring_ct == RING_LAST) begin
          w_state_next = ST_DONE;
        end else begin
          w_ring_ct_next = r_ring_ct + 7'd1;
          w_phase_next   = ~r_phase;
        end
      end

      ST_SNOOZE: begin
        if (!alarm_on) begin
          w_state_next = ST_IDLE;
        end else if (stop) begin
          w_state_next = ST_DONE;
        end else if (r_snz_ct == '0) begin
          w_state_next   = ST_RING;
          w_ring_ct_next = '0;
          w_phase_next   = 1'b1;
        end else begin
          w_snz_ct_next = r_snz_ct - 10'd1;
        end
      end

      ST_DONE: begin
        // Wait out the matching minute so the same alarm cannot retrigger.
        if (!alarm_match) w_state_next = ST_IDLE;
      end

      default: w_state_next = ST_IDLE;
    endcase
  end

  assign ringing  = (r_state == ST_RING);
  assign snoozing = (r_state == ST_SNOOZE);
  assign buzz     = ringing & r_phase;
  assign snz_left = snoozing ? r_snz_ct : 10'd0;
  assign snz_used = r_snz_used;

endmodule
